// File: rtl/mem_stage_control.sv
// MEM-stage control: resolves BNE/BEQ/Jump/Jr into PCSrc + Redirect + multi-cycle Flush, and sequences data-memory accesses with Stall.
// Outputs registered one cycle after the ControlM sample; define MEM_TIMEOUT_EN to abort stuck accesses (sticky MemTimeout).
module mem_stage_control #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned WAIT_LIMIT   = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] ControlM,
  input  logic       ZeroM,
  input  logic       MemReady,
  output logic [1:0] PCSrc,
  output logic       Redirect,
  output logic       Flush,
  output logic       Stall,
  output logic       MemReq,
  output logic       MemWe,
  output logic       MemTimeout
);

  if (FLUSH_CYCLES == 0 || FLUSH_CYCLES > 15 || WAIT_LIMIT == 0 || WAIT_LIMIT > 255) begin : g_param_check
    $error("mem_stage_control: FLUSH_CYCLES must be 1..15 and WAIT_LIMIT 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam state_t     TAKEN_NEXT = (FLUSH_CYCLES > 1) ? S_FLUSH : S_IDLE;

  state_t     r_state;
  logic [3:0] r_flush_cnt;
  logic [1:0] r_pcsrc;
  logic       r_redirect;
  logic       r_flush;
  logic       r_stall;
  logic       r_mem_req;
  logic       r_mem_we;

  logic       w_jr;
  logic       w_jump;
  logic       w_beq_taken;
  logic       w_bne_taken;
  logic       w_taken;
  logic       w_mem_access;
  logic [1:0] w_target;

  assign w_jr         = ControlM[5];
  assign w_jump       = ControlM[4];
  assign w_beq_taken  = ControlM[1] & ZeroM;
  assign w_bne_taken  = ControlM[0] & ~ZeroM;
  assign w_taken      = w_jr | w_jump | w_beq_taken | w_bne_taken;
  assign w_mem_access = ControlM[2] | ControlM[3];

  // Jr outranks Jump, which outranks either conditional branch
  always_comb begin
    w_target = 2'b00;
    if (w_jr)
      w_target = 2'b11;
    else if (w_jump)
      w_target = 2'b10;
    else if (w_beq_taken || w_bne_taken)
      w_target = 2'b01;
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  logic [7:0] r_wait_cnt;
  logic       r_timeout;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_flush_cnt <= 4'd0;
      r_pcsrc     <= 2'b00;
      r_redirect  <= 1'b0;
      r_flush     <= 1'b0;
      r_stall     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_wait_cnt  <= 8'd0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pcsrc    <= 2'b00;
          r_redirect <= 1'b0;
          r_flush    <= 1'b0;
          r_stall    <= 1'b0;
          r_mem_req  <= 1'b0;
          r_mem_we   <= 1'b0;
          // A taken transfer squashes any memory bits riding on the same bundle
          if (w_taken) begin
            r_pcsrc     <= w_target;
            r_redirect  <= 1'b1;
            r_flush     <= 1'b1;
            r_flush_cnt <= FLUSH_LOAD;
            r_state     <= TAKEN_NEXT;
          end else if (w_mem_access) begin
            r_mem_req <= 1'b1;
            r_mem_we  <= ControlM[3];
            r_stall   <= 1'b1;
            r_state   <= S_MEM_WAIT;
`ifdef MEM_TIMEOUT_EN
            r_wait_cnt <= 8'd0;
`endif
          end
        end

        S_FLUSH: begin
          r_pcsrc    <= 2'b00;
          r_redirect <= 1'b0;
          if (r_flush_cnt == 4'd0) begin
            r_flush <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
          end
        end

        S_MEM_WAIT: begin
          if (MemReady) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_stall   <= 1'b0;
            r_state   <= S_IDLE;
`ifdef MEM_TIMEOUT_EN
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_stall   <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
`endif
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign PCSrc    = r_pcsrc;
  assign Redirect = r_redirect;
  assign Flush    = r_flush;
  assign Stall    = r_stall;
  assign MemReq   = r_mem_req;
  assign MemWe    = r_mem_we;
`ifdef MEM_TIMEOUT_EN
  assign MemTimeout = r_timeout;
`else
  assign MemTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_control.sv
// Bench for mem_stage_control: directed plan items then random ControlM/ZeroM/MemReady against a per-cycle output schedule model.
module tb_mem_stage_control;
  localparam int FC = 2;
  localparam int WL = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] ControlM;
  logic       ZeroM;
  logic       MemReady;
  logic [1:0] PCSrc;
  logic       Redirect, Flush, Stall, MemReq, MemWe, MemTimeout;

  mem_stage_control #(
    .FLUSH_CYCLES(FC),
    .WAIT_LIMIT  (WL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ControlM  (ControlM),
    .ZeroM     (ZeroM),
    .MemReady  (MemReady),
    .PCSrc     (PCSrc),
    .Redirect  (Redirect),
    .Flush     (Flush),
    .Stall     (Stall),
    .MemReq    (MemReq),
    .MemWe     (MemWe),
    .MemTimeout(MemTimeout)
  );

  always #5 clk = ~clk;

  // One entry per future cycle: expected outputs, whether the block is busy
  // (will not sample ControlM at the closing edge), and the MemReady to drive.
  typedef struct packed {
    logic [1:0] pcsrc;
    logic       redirect;
    logic       flush;
    logic       stall;
    logic       req;
    logic       we;
    logic       busy;
    logic       rdy;
    logic       abort;
  } ent_t;

  ent_t q[$];
  ent_t cur;
  logic exp_tmo;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  function automatic logic [7:0] obs_vec();
    return {PCSrc, Redirect, Flush, Stall, MemReq, MemWe, MemTimeout};
  endfunction

  task automatic check(input string tag, input logic [7:0] exp);
    checks++;
    assert (obs_vec() === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs_vec(), exp);
    end
  endtask

  task automatic plan(input logic [5:0] ctl, input logic z, input int nwait);
    ent_t       e;
    logic       taken;
    logic [1:0] src;
    bit         abort;
    int         len;
    taken = ctl[5] | ctl[4] | (ctl[1] & z) | (ctl[0] & ~z);
    if (taken) begin
      src = ctl[5] ? 2'd3 : (ctl[4] ? 2'd2 : 2'd1);
      for (int i = 0; i < FC; i++) begin
        e = '0;
        e.flush = 1'b1;
        e.busy  = (FC > 1);
        if (i == 0) begin
          e.pcsrc    = src;
          e.redirect = 1'b1;
        end
        q.push_back(e);
      end
    end else if (ctl[2] | ctl[3]) begin
      abort = TMO_EN && (nwait >= WL);
      len   = abort ? WL : nwait + 1;
      for (int j = 0; j < len; j++) begin
        e = '0;
        e.req   = 1'b1;
        e.we    = ctl[3];
        e.stall = 1'b1;
        e.busy  = 1'b1;
        e.rdy   = (j == nwait);
        e.abort = abort && (j == len - 1);
        q.push_back(e);
      end
    end
  endtask

  // Called at a falling edge: check this cycle, drive inputs, advance the model.
  task automatic cycle(input logic [5:0] ctl, input logic z, input int nwait);
    check($sformatf("cyc%0d", cyc),
          {cur.pcsrc, cur.redirect, cur.flush, cur.stall, cur.req, cur.we, exp_tmo});
    ControlM = ctl;
    ZeroM    = z;
    MemReady = cur.req ? cur.rdy : 1'($urandom);
    @(posedge clk);
    if (cur.abort) exp_tmo = 1'b1;
    if (!cur.busy) plan(ctl, z, nwait);
    cur = (q.size() > 0) ? q.pop_front() : '0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(6'b000000, 1'($urandom), 0);
  endtask

  task automatic do_reset_mid();
    reset = 1'b1;
    #1;
    check("async_reset", 8'h00);
    q.delete();
    cur     = '0;
    exp_tmo = 1'b0;
    @(posedge clk);
    #1;
    check("reset_hold", 8'h00);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    ControlM = 6'b000000;
    ZeroM    = 1'b0;
    MemReady = 1'b0;
    cur      = '0;
    exp_tmo  = 1'b0;
    @(negedge clk);
    check("reset_state", 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // BEQ taken; the write arriving during the flush must be ignored
    cycle(6'b000010, 1'b1, 0);
    cycle(6'b001000, 1'b0, 0);
    cycle(6'b001000, 1'b0, 0);
    idle(2);

    // not-taken branches, then Jr winning over Jump and BEQ
    cycle(6'b000001, 1'b1, 0);
    cycle(6'b000010, 1'b0, 0);
    cycle(6'b110010, 1'b1, 0);
    idle(3);
    cycle(6'b010001, 1'b0, 0);
    idle(3);
    cycle(6'b001101, 1'b0, 0);
    idle(3);

    // write with 3 wait cycles, immediate read, read+write treated as write
    cycle(6'b001000, 1'b0, 3);
    idle(5);
    cycle(6'b000100, 1'b0, 0);
    idle(2);
    cycle(6'b001100, 1'b1, 1);
    idle(3);

    // long wait: aborts when the timeout is built, otherwise completes late
    cycle(6'b001000, 1'b0, 10);
    idle(12);
    cycle(6'b000100, 1'b0, 0);
    idle(2);

    // reset in the middle of an outstanding access
    cycle(6'b001000, 1'b0, 8);
    idle(2);
    do_reset_mid();
    idle(3);

    for (int r = 0; r < 800; r++) begin
      if ($urandom_range(0, 199) == 0) do_reset_mid();
      cycle(($urandom_range(0, 3) == 0) ? 6'b000000 : 6'($urandom),
            1'($urandom), int'($urandom_range(0, 6)));
    end
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_control.md
# mem_stage_control

MEM-stage consumer of the 6-bit EX/MEM control bundle. It resolves control transfers (BNE, BEQ, Jump, Jr) into a PC-source select, a one-cycle redirect pulse and a multi-cycle flush of the younger stages. It also sequences data-memory accesses against a ready handshake, stalling the upstream pipeline while an access is outstanding. It sits between the EX/MEM pipeline register and the PC mux, the hazard/flush logic and the data memory.

## Interface
Parameters:
- FLUSH_CYCLES, 2: number of cycles Flush stays high after a redirect (1..15).
- WAIT_LIMIT, 15: maximum MEM_WAIT cycles before abort; used only with MEM_TIMEOUT_EN (1..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ControlM  in  6  control bundle from the EX/MEM register: [0] BranchNE, [1] BranchEQ, [2] MemRead, [3] MemWrite, [4] Jump, [5] Jr.
- ZeroM  in  1  registered ALU zero flag for the same instruction.
- MemReady  in  1  data-memory completion acknowledge.
- PCSrc  out  2  PC select: 00 PC+4, 01 branch target, 10 jump target, 11 Jr register.
- Redirect  out  1  one-cycle pulse; PC loads the PCSrc target.
- Flush  out  1  squash IF/ID and ID/EX contents.
- Stall  out  1  freeze PC and upstream pipeline registers.
- MemReq  out  1  data-memory request, held until acknowledged.
- MemWe  out  1  write enable; valid while MemReq is high.
- MemTimeout  out  1  sticky access-abort flag.

## Operation
- States: IDLE, FLUSH, MEM_WAIT. All outputs are registered.
- Reset (asynchronous, any state, mid-access included): state IDLE; flush counter 0; wait counter 0; all outputs 0; PCSrc 00.
- IDLE samples ControlM and ZeroM on each edge. Decode priority is Jr, then Jump, then (BranchEQ & ZeroM), then (BranchNE & ~ZeroM).
- Taken transfer:
  - Registered outputs: PCSrc 11, 10 or 01 respectively; Redirect 1; Flush 1.
  - Flush counter loads FLUSH_CYCLES-1. State goes to FLUSH, or stays IDLE for one cycle when FLUSH_CYCLES=1.
- A taken transfer has priority over the memory bits. If MemRead or MemWrite is also set, the memory bits are ignored and no access starts.
- Not-taken branch: PCSrc stays 00 and no pulse is issued.
- MemRead or MemWrite with no taken transfer:
  - State goes to MEM_WAIT.
  - MemReq 1; MemWe = MemWrite; Stall 1.
  - If both MemRead and MemWrite are set, the access is a write.
- FLUSH:
  - Redirect 0; PCSrc 00; Flush stays 1; ControlM is ignored because it carries squashed instructions.
  - The counter decrements each cycle. At 0, Flush is cleared and state returns to IDLE.
- MEM_WAIT:
  - ControlM is ignored; MemReq, MemWe and Stall are held.
  - On an edge with MemReady=1, the registered outputs clear MemReq, MemWe and Stall, and state returns to IDLE.
- Only one outstanding access exists at a time. There is no back-to-back bypass: IDLE re-samples ControlM starting the cycle after completion.

## Timing
- Latency: a ControlM sample at edge t drives outputs in the cycle after t.
- Redirect is high for exactly one cycle.
- Flush is high for exactly FLUSH_CYCLES consecutive cycles, starting in the same cycle as Redirect.
- PCSrc is non-zero only during the Redirect cycle.
- Memory access takes a minimum of 1 cycle with MemReq high, when MemReady is already 1 at the first wait edge. With N cycles of MemReady=0, MemReq and Stall stay high for N+1 cycles.
- MemReady is ignored outside MEM_WAIT.
- An IDLE cycle with ControlM=000000 produces all-zero outputs in the next cycle.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit wait counter runs in MEM_WAIT.
  - If WAIT_LIMIT consecutive wait cycles pass without MemReady, the access aborts: MemReq, MemWe and Stall clear, state returns to IDLE, and MemTimeout sets.
  - MemTimeout stays set until reset.
  - If MemReady arrives on the limit edge, the access completes normally with no timeout.
- MEM_TIMEOUT_EN undefined: MEM_WAIT waits indefinitely; MemTimeout is tied to 0; the wait counter is not built.

## Test plan
- Reset: assert reset mid-MEM_WAIT with MemReq=1 -> all outputs 0 immediately (asynchronous), state IDLE; with ControlM=0 afterwards, outputs stay 0.
- BEQ taken: ControlM=000010, ZeroM=1, FLUSH_CYCLES=2 -> next cycle PCSrc=01 and Redirect=1; Flush high for exactly 2 cycles; the ControlM=001000 applied during the flush is ignored (MemReq stays 0).
- Branch not taken and priority: ControlM=000001 with ZeroM=1 -> no redirect; ControlM=110010 with ZeroM=1 -> PCSrc=11 (Jr wins), Redirect=1.
- Write with 3 wait cycles: ControlM=001000, MemReady low for 3 edges then high -> MemReq=MemWe=Stall=1 for 4 cycles, then all 0.
- Read with immediate ready: ControlM=000100, MemReady=1 -> MemReq=1 and MemWe=0 for 1 cycle.
- MEM_TIMEOUT_EN, WAIT_LIMIT=4, MemReady held 0 -> abort after 4 wait cycles; MemTimeout=1 and remains 1 through subsequent accesses until reset.
